lfsr_stream_cipher_8: RTL and testbench
=======================================

LFSR_STREAM_CIPHER_8 -- requirements
Module: lfsr_stream_cipher_8

Interface
REQ-001 Parameter: COUNT_WIDTH, default 16, width of the byte_count output.
REQ-002 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-003 Port `clock`: input, 1 bit; sole clock; all state updates on its rising edge.
REQ-004 Port `reset_n`: input, 1 bit; asynchronous, active-low reset.
REQ-005 Port `clear`: input, 1 bit; synchronous return to EMPTY.
REQ-006 Port `key_byte`: input, 8 bits; key byte.
REQ-007 Port `key_valid`: input, 1 bit; key byte offered.
REQ-008 Port `key_ready`: output, 1 bit; key byte acceptable.
REQ-009 Port `in_data`: input, 8 bits; ciphertext or plaintext byte.
REQ-010 Port `in_valid`: input, 1 bit; in_data offered.
REQ-011 Port `in_ready`: output, 1 bit; in_data acceptable.
REQ-012 Port `out_data`: output, 8 bits; in_data XOR keystream byte.
REQ-013 Port `out_valid`: output, 1 bit; out_data holds an untaken result.
REQ-014 Port `out_ready`: input, 1 bit; consumer takes out_data.
REQ-015 Port `key_loaded`: output, 1 bit; high when the FSM is in READY.
REQ-016 Port `byte_count`: output, COUNT_WIDTH bits; number of data transfers since the last key load began.

Function
REQ-017 Keystream state: eight 16-bit lanes, L0..L7, identical to the team's 16-bit, 8-lane keystream generator, so that encrypt and decrypt are the same operation.
REQ-018 Key accept: on key_valid && key_ready, shift one byte per accept along this chain:
- key_byte -> L0[7:0]
- L(i)[7:0] -> L(i)[15:8]
- L(i)[15:8] -> L(i+1)[7:0]
- L7[15:8] is discarded.
REQ-019 Key fill order: after 16 accepted bytes, the first byte accepted sits in L7[15:8] and the last in L0[7:0].
REQ-020 Step: each lane computes new = {old[14:0], f}, where f = old[14]^old[12]^old[11]^old[10].
REQ-021 Keystream byte: the byte produced by a step is {L0[0],L1[0],...,L7[0]} taken from the new values (L0 is the MSB).
REQ-022 Step trigger: exactly one step per data transfer (in_valid && in_ready); the lanes are otherwise held.
REQ-023 Output register: on a transfer, out_data <= in_data ^ keystream and out_valid <= 1 on that edge (latency 1 cycle, throughput 1 byte/cycle).
REQ-024 Output hold: out_valid and out_data are held while out_valid && !out_ready.
REQ-025 Output drain: out_valid falls on the edge where out_ready is high and no new transfer occurs.
REQ-026 in_ready = (state==READY) && !key_valid && (!out_valid || out_ready).
REQ-027 key_ready = !out_valid && !clear.
REQ-028 FSM EMPTY: key count 0; the first accepted key byte moves the FSM to LOADING with key count 1.
REQ-029 FSM LOADING: each accepted key byte increments the 4-bit key count; the 16th accepted byte moves the FSM to READY.
REQ-030 FSM READY: an accepted key byte starts a new load, moving the FSM to LOADING with key count 1; existing lane contents shift per REQ-018 and are not zeroed.
REQ-031 byte_count is zeroed on any key accept, increments on each transfer, and wraps from all-ones to 0.
REQ-032 Simultaneous key_valid and in_valid in READY: the key byte wins and no data transfer occurs that cycle (REQ-026).
REQ-033 Key offered while out_valid is high: key_ready is low and the byte is not accepted until the output drains.
REQ-034 clear is synchronous and has priority over all other inputs; when high on an edge:
- lanes <= 0, key count <= 0, byte_count <= 0
- out_valid <= 0
- FSM <= EMPTY.
REQ-035 in_valid while the FSM is in EMPTY or LOADING: in_ready is low, so no transfer and no step occur.

Reset
REQ-036 When reset_n is low (asynchronous, mid-operation included), the block is forced to:
- lanes = 0
- FSM = EMPTY, key count = 0
- out_valid = 0, out_data = 0x00
- byte_count = 0, key_loaded = 0
- in_ready = 0, key_ready = 1.
REQ-037 After reset_n rises, the first rising clock edge operates normally.

Verification
REQ-038 Identity key: load 16x 0x00, then send 0x5A, 0xC3 -> out_data 0x5A, 0xC3, each 1 cycle after its transfer; byte_count = 2.
REQ-039 Single-bit key: load 15x 0x00 then 0x01, then send 11x 0x00 -> outputs 0x00 x10 then 0x80 on the 11th.
REQ-040 Round trip: encrypt 32 bytes under key K, reload K, feed the outputs back -> original 32 bytes recovered exactly.
REQ-041 Backpressure: hold out_ready=0 after one transfer -> out_valid stays 1 with out_data stable, in_ready=0 and key_ready=0, no step occurs; releasing out_ready gives back-to-back 1 byte/cycle.
REQ-042 Collision and reload: in READY, assert key_valid with in_valid -> no transfer, FSM LOADING, key count 1, byte_count 0, key_loaded 0.
REQ-043 Reset and clear mid-stream: assert clear, or reset_n=0 asynchronously, after 5 transfers -> all REQ-036 values hold on the next edge (clear) or immediately (reset_n), and in_ready stays 0 until 16 new key bytes are accepted.

Source files
------------

// File: rtl/lfsr_stream_cipher_8.sv
// Byte-wide stream cipher: eight 16-bit LFSR lanes keyed by a 16-byte shift-in
// load, one lane step per data byte. Encrypt and decrypt are the same operation.
module lfsr_stream_cipher_8 #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [7:0]             key_byte,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   key_loaded,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  localparam int LANES = 8;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    READY
  } state_t;

  state_t                 state;
  logic [3:0]             key_count;
  logic [LANES-1:0][15:0] lanes;
  logic [LANES-1:0][15:0] stepped;
  logic [LANES-1:0][15:0] shifted;
  logic [7:0]             keystream;
  logic                   key_accept;
  logic                   transfer;

  // One Fibonacci step of a single lane: shift left, feedback from bits 14/12/11/10.
  function automatic logic [15:0] lane_step(input logic [15:0] v);
    return {v[14:0], v[14] ^ v[12] ^ v[11] ^ v[10]};
  endfunction

  assign key_ready  = !out_valid && !clear;
  assign in_ready   = (state == READY) && !key_valid && (!out_valid || out_ready);
  assign key_loaded = (state == READY);
  assign key_accept = key_valid && key_ready;
  assign transfer   = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    stepped   = '0;
    shifted   = '0;
    keystream = '0;
    for (int i = 0; i < LANES; i++) begin
      stepped[i]           = lane_step(lanes[i]);
      keystream[LANES-1-i] = stepped[i][0];
    end
    shifted[0] = {lanes[0][7:0], key_byte};
    for (int i = 1; i < LANES; i++) begin
      shifted[i] = {lanes[i][7:0], lanes[i-1][15:8]};
    end
  end

  // NOTE: state is written with non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the statements appear in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the lanes are a packed bank of flops rather than a RAM, so they
      // take the asynchronous reset like any other register.
      lanes      <= '0;
      state      <= EMPTY;
      key_count  <= 4'd0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      byte_count <= '0;
    end else if (clear) begin
      lanes      <= '0;
      state      <= EMPTY;
      key_count  <= 4'd0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      byte_count <= '0;
    end else if (key_accept) begin
      lanes      <= shifted;
      byte_count <= '0;
      case (state)
        LOADING: begin
          key_count <= key_count + 4'd1;
          if (key_count == 4'd15) state <= READY;
        end
        default: begin
          // A key byte in EMPTY or READY starts a fresh 16-byte load.
          key_count <= 4'd1;
          state     <= LOADING;
        end
      endcase
    end else if (transfer) begin
      lanes      <= stepped;
      out_data   <= in_data ^ keystream;
      out_valid  <= 1'b1;
      byte_count <= byte_count + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_cipher_8.sv
// Self-checking bench: a 128-bit shift-register model of the key/lane state is
// compared against the DUT every cycle, with hand-computed vectors pinning the model.
module tb_lfsr_stream_cipher_8;

  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear;
  logic [7:0]    key_byte;
  logic          key_valid;
  logic          key_ready;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          key_loaded;
  logic [CW-1:0] byte_count;

  lfsr_stream_cipher_8 #(.COUNT_WIDTH(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .key_byte   (key_byte),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .key_loaded (key_loaded),
    .byte_count (byte_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // The 16 key bytes form one 128-bit shift register; lane i is bits [16i+15:16i].
  logic [127:0]  m_s;
  int            m_state;   // 0 EMPTY, 1 LOADING, 2 READY
  int            m_kc;
  logic [CW-1:0] m_bc;
  logic          m_ov;
  logic [7:0]    m_od;
  bit            m_kacc;
  bit            m_xfer;
  logic [7:0]    m_out_q[$];
  logic [15:0]   m_lane;
  logic          m_f;
  logic [7:0]    m_ks;

  always @(posedge clock or negedge reset_n) begin
    m_kacc = 1'b0;
    m_xfer = 1'b0;
    if (!reset_n || clear) begin
      m_s = '0; m_state = 0; m_kc = 0; m_bc = '0; m_ov = 1'b0; m_od = 8'h00;
    end else if (key_valid && !m_ov) begin
      m_kacc = 1'b1;
      m_s    = {m_s[119:0], key_byte};
      m_bc   = '0;
      if (m_state == 1) begin
        m_kc = m_kc + 1;
        if (m_kc == 16) begin m_state = 2; m_kc = 0; end
      end else begin
        m_state = 1; m_kc = 1;
      end
    end else if (in_valid && !key_valid && m_state == 2 && (!m_ov || out_ready)) begin
      m_xfer = 1'b1;
      m_ks   = 8'h00;
      for (int i = 0; i < 8; i++) begin
        m_lane = m_s[16*i +: 16];
        m_f    = ^(m_lane & 16'h5C00);
        m_s[16*i +: 16] = ((m_lane << 1) | {15'd0, m_f});
        m_ks[7-i] = m_f;
      end
      m_od = in_data ^ m_ks;
      m_ov = 1'b1;
      m_bc = m_bc + 1'b1;
      m_out_q.push_back(m_od);
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cmp_out_valid",  32'(out_valid),  32'(m_ov));
      check("cmp_out_data",   32'(out_data),   32'(m_od));
      check("cmp_byte_count", 32'(byte_count), 32'(m_bc));
      check("cmp_key_loaded", 32'(key_loaded), 32'(m_state == 2));
      check("cmp_key_ready",  32'(key_ready),  32'(!m_ov && !clear));
      check("cmp_in_ready",   32'(in_ready),
            32'(m_state == 2 && !key_valid && (!m_ov || out_ready)));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] key_arr[16];
  logic [7:0] plain[32];
  logic [7:0] cipher[32];

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic send_key(input logic [7:0] b);
    key_valid = 1'b1; key_byte = b; in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      cyc();
      if (m_kacc) break;
    end
    check("key_accept_bound", 32'(m_kacc), 1);
    key_valid = 1'b0;
    #1;
  endtask

  task automatic load_key_arr();
    for (int k = 0; k < 16; k++) send_key(key_arr[k]);
  endtask

  task automatic send_byte(input logic [7:0] d);
    in_valid = 1'b1; in_data = d; key_valid = 1'b0; out_ready = 1'b1;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; key_byte = 8'h00; key_valid = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    check("rst_out_valid",  32'(out_valid),  0);
    check("rst_out_data",   32'(out_data),   0);
    check("rst_byte_count", 32'(byte_count), 0);
    check("rst_key_loaded", 32'(key_loaded), 0);
    check("rst_in_ready",   32'(in_ready),   0);
    check("rst_key_ready",  32'(key_ready),  1);

    // Data offered before any key: never accepted
    in_valid = 1'b1; in_data = 8'hAA;
    cyc();
    check("empty_in_ready", 32'(in_ready), 0);
    check("empty_no_out",   32'(out_valid), 0);

    // Identity key: all-zero lanes pass data through
    for (int k = 0; k < 16; k++) send_key(8'h00);
    check("id_key_loaded", 32'(key_loaded), 1);
    send_byte(8'h5A);
    check("id_out0", 32'(out_data), 'h5A);
    check("id_vld0", 32'(out_valid), 1);
    send_byte(8'hC3);
    check("id_out1", 32'(out_data), 'hC3);
    in_valid = 1'b0;
    check("id_count", 32'(byte_count), 2);

    // Single-bit key: L0 = 0x0001, feedback reaches L0 bit 0 on step 11
    for (int k = 0; k < 15; k++) send_key(8'h00);
    send_key(8'h01);
    for (int k = 1; k <= 11; k++) begin
      send_byte(8'h00);
      check("bit_out", 32'(out_data), (k == 11) ? 'h80 : 'h00);
    end

    // Backpressure with a key offered: output held, no step, no key accept
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    key_valid = 1'b1; key_byte = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("bp_valid",     32'(out_valid),  1);
      check("bp_data",      32'(out_data),   'h80);
      check("bp_in_ready",  32'(in_ready),   0);
      check("bp_key_ready", 32'(key_ready),  0);
      check("bp_count",     32'(byte_count), 11);
      check("bp_loaded",    32'(key_loaded), 1);
    end
    key_valid = 1'b0;
    // Steps 12..15 of the lane sequence, back to back
    send_byte(8'h00); check("bp_rel0", 32'(out_data), 'h80);
    send_byte(8'h00); check("bp_rel1", 32'(out_data), 'h80);
    send_byte(8'h00); check("bp_rel2", 32'(out_data), 'h00);
    send_byte(8'h00); check("bp_rel3", 32'(out_data), 'h80);
    check("bp_count_end", 32'(byte_count), 15);

    // Collision in READY: key wins, no transfer
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    key_valid = 1'b1; key_byte = 8'h00; in_valid = 1'b1; in_data = 8'h77;
    cyc();
    check("col_valid",  32'(out_valid),  0);
    check("col_count",  32'(byte_count), 0);
    check("col_loaded", 32'(key_loaded), 0);
    key_valid = 1'b0;
    cyc();
    check("col_in_ready", 32'(in_ready),  0);
    check("col_no_out",   32'(out_valid), 0);
    in_valid = 1'b0;

    // Round trip under a random key
    for (int k = 0; k < 16; k++) key_arr[k] = 8'($urandom);
    for (int k = 0; k < 32; k++) plain[k] = 8'($urandom);
    clear = 1'b1; cyc(); clear = 1'b0;
    load_key_arr();
    m_out_q.delete();
    for (int k = 0; k < 32; k++) send_byte(plain[k]);
    in_valid = 1'b0;
    for (int k = 0; k < 32; k++) cipher[k] = m_out_q[k];
    load_key_arr();
    for (int k = 0; k < 32; k++) begin
      send_byte(cipher[k]);
      check("roundtrip", 32'(out_data), 32'(plain[k]));
    end
    in_valid = 1'b0;

    // Clear mid-stream, with competing inputs
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    clear = 1'b1; in_valid = 1'b1; key_valid = 1'b1; key_byte = 8'h33;
    cyc();
    check("clr_valid",     32'(out_valid),  0);
    check("clr_data",      32'(out_data),   0);
    check("clr_count",     32'(byte_count), 0);
    check("clr_loaded",    32'(key_loaded), 0);
    check("clr_in_ready",  32'(in_ready),   0);
    check("clr_key_ready", 32'(key_ready),  0);
    clear = 1'b0; key_valid = 1'b0;
    #1 check("clr_key_ready_rel", 32'(key_ready), 1);
    cyc();
    check("clr_in_ready_idle", 32'(in_ready), 0);
    for (int k = 0; k < 15; k++) send_key(8'($urandom));
    in_valid = 1'b1;
    #1 check("clr_in_ready_15", 32'(in_ready), 0);
    send_key(8'($urandom));
    in_valid = 1'b1;
    #1 check("clr_in_ready_16", 32'(in_ready), 1);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid",     32'(out_valid),  0);
    check("arst_data",      32'(out_data),   0);
    check("arst_count",     32'(byte_count), 0);
    check("arst_loaded",    32'(key_loaded), 0);
    check("arst_in_ready",  32'(in_ready),   0);
    check("arst_key_ready", 32'(key_ready),  1);
    cyc();
    reset_n = 1'b1;
    cyc();
    check("arst_in_ready_after", 32'(in_ready), 0);
    for (int k = 0; k < 16; k++) send_key(8'($urandom));
    in_valid = 1'b1;
    #1 check("arst_in_ready_16", 32'(in_ready), 1);

    // Randomised traffic: keys, reloads, clears and backpressure
    for (int r = 0; r < 12; r++) begin
      clear = 1'b1; cyc(); clear = 1'b0;
      for (int k = 0; k < 16; k++) key_arr[k] = 8'($urandom);
      load_key_arr();
      for (int c = 0; c < 120; c++) begin
        in_valid  = ($urandom_range(3) != 0);
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(3) != 0);
        key_valid = ($urandom_range(40) == 0);
        key_byte  = 8'($urandom);
        clear     = ($urandom_range(200) == 0);
        cyc();
      end
      clear = 1'b0; key_valid = 1'b0; in_valid = 1'b0;
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
